// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the CPU MEM stage (master) and the data-memory responder (slave).
// Handshake: master holds ENABLE/EDIT_SERIAL until accepted; slave pulses finish_flag once per accepted request.
`timescale 1ns/1ps
interface data_mem_responder_if;
   logic        ENABLE;
   logic [64:0] EDIT_SERIAL;
   logic [31:0] DATA;
   logic        finish_flag;
   logic        BUSY;
   logic        ERROR;

   modport master (output ENABLE, output EDIT_SERIAL,
                   input DATA, input finish_flag, input BUSY, input ERROR);
   modport slave  (input ENABLE, input EDIT_SERIAL,
                   output DATA, output finish_flag, output BUSY, output ERROR);
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle word memory responder: accepts one request, waits LATENCY edges, performs the
// access and returns a one-cycle finish_flag with registered DATA/ERROR.
`timescale 1ns/1ps
module data_mem_responder #(
   parameter int DEPTH_WORDS = 512,
   parameter int LATENCY     = 3
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   data_mem_responder_if.slave   bus,
   output logic [1:0]            dbg_state
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [64:0] req_q, req_d;
   logic [31:0] data_q, data_d;
   logic        fin_q, fin_d;
   logic        err_q, err_d;
   logic        mem_we;

   logic [31:0] mem [DEPTH_WORDS];

   logic             req_we;
   logic [31:0]      req_addr;
   logic [31:0]      req_wdata;
   logic [IDX_W-1:0] req_idx;
   logic             req_bad;

   assign req_we    = req_q[64];
   assign req_addr  = req_q[63:32];
   assign req_wdata = req_q[31:0];
   assign req_idx   = req_addr[IDX_W+1:2];
   // Upper address bits are not masked: any index past the array is an error, not an alias.
   assign req_bad   = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      data_d  = data_q;
      fin_d   = 1'b0;
      err_d   = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.ENABLE) begin
               req_d   = bus.EDIT_SERIAL;
               cnt_d   = 4'(LATENCY);
               state_d = WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q > 4'd1) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = DONE;
               fin_d   = 1'b1;
               if (req_bad) begin
                  err_d  = 1'b1;
                  data_d = 32'd0;
               end else if (req_we) begin
                  mem_we = !RESET;
               end else begin
                  data_d = mem[req_idx];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         req_q   <= 65'd0;
         data_q  <= 32'd0;
         fin_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         data_q  <= data_d;
         fin_q   <= fin_d;
         err_q   <= err_d;
      end
   end

   // Array contents survive reset; only the in-flight write is suppressed.
   always_ff @(posedge CLOCK) begin
      if (mem_we) mem[req_idx] <= req_wdata;
   end

   assign bus.DATA        = data_q;
   assign bus.finish_flag = fin_q;
   assign bus.ERROR       = err_q;
   assign bus.BUSY        = (state_q == WAIT);
   assign dbg_state       = state_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: two instances (LATENCY 3 and 1) sharing clock and reset,
// expected {ERROR,DATA} responses queued at issue time and popped on finish_flag.
`timescale 1ns/1ps
module tb_data_mem_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   data_mem_responder_if bus3();
   data_mem_responder_if bus1();
   logic [1:0] st3, st1;

   data_mem_responder #(.DEPTH_WORDS(512), .LATENCY(3)) dut3 (
      .CLOCK(clk), .RESET(rst), .bus(bus3.slave), .dbg_state(st3));
   data_mem_responder #(.DEPTH_WORDS(512), .LATENCY(1)) dut1 (
      .CLOCK(clk), .RESET(rst), .bus(bus1.slave), .dbg_state(st1));

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q[$];

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic en, input logic [64:0] ser);
      if (sel) begin
         bus1.ENABLE = en; bus1.EDIT_SERIAL = ser;
      end else begin
         bus3.ENABLE = en; bus3.EDIT_SERIAL = ser;
      end
   endtask

   task automatic sample(input bit sel, output logic fin, output logic busy,
                         output logic err, output logic [31:0] data);
      if (sel) begin
         fin = bus1.finish_flag; busy = bus1.BUSY; err = bus1.ERROR; data = bus1.DATA;
      end else begin
         fin = bus3.finish_flag; busy = bus3.BUSY; err = bus3.ERROR; data = bus3.DATA;
      end
   endtask

   // Present one request for a single accept edge; now=1 drives immediately (DONE-cycle chaining).
   task automatic issue(input bit sel, input bit now, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic err, input logic [31:0] data);
      if (!now) @(negedge clk);
      drive(sel, 1'b1, {we, addr, wdata});
      exp_q.push_back({err, data});
      @(posedge clk);
      #1 drive(sel, 1'b0, 65'd0);
   endtask

   // Samples each negedge after the accept edge: BUSY-only for LATENCY cycles, then finish_flag.
   task automatic wait_done(input bit sel, input int lat, input bit intrude, input string tag);
      logic fin, busy, err;
      logic [31:0] data;
      logic [32:0] exp;
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clk);
         sample(sel, fin, busy, err, data);
         if (intrude && k == 1) drive(sel, 1'b1, {1'b1, 32'h0000_0010, 32'h0000_0001});
         if (intrude && k == lat) drive(sel, 1'b0, 65'd0);
         if (k <= lat) begin
            check({tag, "_wait"}, {31'd0, fin, busy}, 33'd1);
         end else begin
            check({tag, "_done"}, {31'd0, fin, busy}, 33'd2);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL %s_sb: observed empty queue expected pending response", tag);
            end else begin
               exp = exp_q.pop_front();
               check({tag, "_resp"}, {err, data}, exp);
            end
         end
      end
   endtask

   task automatic check_quiet(input bit sel, input string tag, input logic [31:0] exp_data);
      logic fin, busy, err;
      logic [31:0] data;
      sample(sel, fin, busy, err, data);
      check({tag, "_flags"}, {30'd0, fin, busy, err}, 33'd0);
      check({tag, "_data"}, {1'b0, data}, {1'b0, exp_data});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(1'b0, 1'b0, 65'd0);
      drive(1'b1, 1'b0, 65'd0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_quiet(1'b0, "reset3", 32'd0);
      check_quiet(1'b1, "reset1", 32'd0);
      check("reset3_state", {31'd0, st3}, 33'd0);
      check("reset1_state", {31'd0, st1}, 33'd0);

      // Write then read back, LATENCY 3
      issue(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
      wait_done(1'b0, 3, 1'b0, "t1_wr");
      @(negedge clk);
      check_quiet(1'b0, "t1_idle", 32'd0);
      issue(1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);
      wait_done(1'b0, 3, 1'b0, "t1_rd");

      // ENABLE during WAIT is dropped
      issue(1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);
      wait_done(1'b0, 3, 1'b1, "t2_rd");
      @(negedge clk);
      check_quiet(1'b0, "t2_idle", 32'hDEADBEEF);
      issue(1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);
      wait_done(1'b0, 3, 1'b0, "t2_rd2");

      // Error paths: misaligned, one past the end, high address bits
      issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 1'b0, 32'hDEADBEEF);
      wait_done(1'b0, 3, 1'b0, "t3_wr0");
      issue(1'b0, 1'b0, 1'b0, 32'h13, 32'd0, 1'b1, 32'd0);
      wait_done(1'b0, 3, 1'b0, "t3_misal");
      issue(1'b0, 1'b0, 1'b1, 32'h800, 32'h5555, 1'b1, 32'd0);
      wait_done(1'b0, 3, 1'b0, "t3_oob");
      issue(1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'd0, 1'b1, 32'd0);
      wait_done(1'b0, 3, 1'b0, "t3_high");
      issue(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0BADF00D);
      wait_done(1'b0, 3, 1'b0, "t3_rd0");

      // Back-to-back: read presented in the DONE cycle of the write
      issue(1'b0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, 32'h0BADF00D);
      wait_done(1'b0, 3, 1'b0, "t4_wr");
      issue(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 32'hA5A5A5A5);
      wait_done(1'b0, 3, 1'b0, "t4_rd");

      // Reset during WAIT aborts the write
      issue(1'b0, 1'b0, 1'b1, 32'h40, 32'h11111111, 1'b0, 32'hA5A5A5A5);
      wait_done(1'b0, 3, 1'b0, "t5_pre");
      @(negedge clk);
      drive(1'b0, 1'b1, {1'b1, 32'h40, 32'h12345678});
      @(posedge clk);
      #1 drive(1'b0, 1'b0, 65'd0);
      @(negedge clk);
      check("t5_busy", {32'd0, bus3.BUSY}, 33'd1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_quiet(1'b0, "t5_abort", 32'd0);
      end
      issue(1'b0, 1'b0, 1'b0, 32'h40, 32'd0, 1'b0, 32'h11111111);
      wait_done(1'b0, 3, 1'b0, "t5_rd");

      // LATENCY 1 instance: completion every 2 cycles when chained
      issue(1'b1, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 1'b0, 32'd0);
      wait_done(1'b1, 1, 1'b0, "t6_wr");
      issue(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 32'hCAFEF00D);
      wait_done(1'b1, 1, 1'b0, "t6_rd");
      issue(1'b1, 1'b1, 1'b1, 32'h14, 32'h00000077, 1'b0, 32'hCAFEF00D);
      wait_done(1'b1, 1, 1'b0, "t6_wr2");
      issue(1'b1, 1'b1, 1'b0, 32'h14, 32'd0, 1'b0, 32'h00000077);
      wait_done(1'b1, 1, 1'b0, "t6_rd2");
      @(negedge clk);
      check_quiet(1'b1, "t6_idle", 32'h00000077);

      check("sb_drained", 33'(exp_q.size()), 33'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
